// File: rtl/irq_ctrl_if.sv
// CPU-side bus and interrupt handshake bundle for irq_ctrl.
// Read data is named dout because "do" is a reserved word in SystemVerilog.
interface irq_ctrl_if;
  logic [15:0] addr;
  logic        we;
  logic [7:0]  di;
  logic [7:0]  dout;
  logic        irq;
  logic [2:0]  irq_vec;
  logic        irq_ack;

  modport master (output addr, we, di, irq_ack, input dout, irq, irq_vec);
  modport slave  (input addr, we, di, irq_ack, output dout, irq, irq_vec);
endinterface

// File: rtl/irq_ctrl.sv
// 8-source interrupt controller: pending/enable registers, fixed priority (bit 0 highest),
// irq/ack handshake with one in-service interrupt. IRQ_EDGE_EN selects edge mode (default: level).
`ifndef ADDR_IRQ_EN
`define ADDR_IRQ_EN   16'h0040
`endif
`ifndef ADDR_IRQ_PEND
`define ADDR_IRQ_PEND 16'h0041
`endif
`ifndef ADDR_IRQ_EOI
`define ADDR_IRQ_EOI  16'h0042
`endif

module irq_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] irq_src,
  irq_ctrl_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

  state_t     state_q, state_d;
  logic [7:0] en_q, en_d;
  logic [7:0] pend_q, pend_d;
  logic [2:0] vec_q, vec_d;
  logic       irq_q, irq_d;
  logic [7:0] set, clr, active;
  logic [2:0] low_idx;
  logic       wr_en, wr_pend, wr_eoi;

`ifdef IRQ_EDGE_EN
  logic [7:0] src_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) src_q <= '0;
    else     src_q <= irq_src;
  end
  assign set = irq_src & ~src_q;
`else
  assign set = irq_src;
`endif

  assign wr_en   = bus.we && (bus.addr == `ADDR_IRQ_EN);
  assign wr_pend = bus.we && (bus.addr == `ADDR_IRQ_PEND);
  assign wr_eoi  = bus.we && (bus.addr == `ADDR_IRQ_EOI);
  assign active  = pend_q & en_q;

  always_comb begin
    low_idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (active[i]) low_idx = 3'(i);
    end
  end

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    en_d    = wr_en ? bus.di : en_q;
    clr     = wr_pend ? bus.di : 8'h00;
    case (state_q)
      IDLE: begin
        if (|active) begin
          vec_d   = low_idx;
          state_d = REQ;
        end
      end
      REQ: begin
        // Ack wins over withdrawal: the request was already taken by the CPU.
        if (bus.irq_ack) begin
          clr[vec_q] = 1'b1;
          state_d    = SERVICE;
        end else if (!active[vec_q]) begin
          state_d = IDLE;
        end
      end
      SERVICE: begin
        if (wr_eoi) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // A new request in the same cycle as a clear keeps the bit pending.
    pend_d = (pend_q & ~clr) | set;
    irq_d  = (state_d == REQ);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      en_q    <= '0;
      pend_q  <= '0;
      vec_q   <= '0;
      irq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      en_q    <= en_d;
      pend_q  <= pend_d;
      vec_q   <= vec_d;
      irq_q   <= irq_d;
    end
  end

  always_comb begin
    case (bus.addr)
      `ADDR_IRQ_EN:   bus.dout = en_q;
      `ADDR_IRQ_PEND: bus.dout = pend_q;
      `ADDR_IRQ_EOI:  bus.dout = {4'b0, (state_q != IDLE), vec_q};
      default:        bus.dout = 8'h00;
    endcase
  end

  assign bus.irq     = irq_q;
  assign bus.irq_vec = vec_q;
endmodule

// File: tb/tb_irq_ctrl.sv
// Directed testbench for irq_ctrl; expected values are hand-derived from the register/FSM behaviour.
module tb_irq_ctrl;
  localparam logic [15:0] A_EN   = 16'h0040;
  localparam logic [15:0] A_PEND = 16'h0041;
  localparam logic [15:0] A_EOI  = 16'h0042;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] irq_src = 8'h00;
  int         checks = 0;
  int         failures = 0;

  irq_ctrl_if bus ();

  irq_ctrl dut (.clk(clk), .rst(rst), .irq_src(irq_src), .bus(bus));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
    bus.addr = a;
    bus.we   = 1'b1;
    bus.di   = d;
    tick();
    bus.we   = 1'b0;
  endtask

  task automatic pulse_ack();
    bus.irq_ack = 1'b1;
    tick();
    bus.irq_ack = 1'b0;
  endtask

  task automatic test_reset();
    tick();
    tick();
    rst = 1'b0;
    bus_write(A_EN, 8'h01);
    irq_src = 8'h01;
    tick();
    irq_src = 8'h00;
    tick();
    checks++;
    if (bus.irq !== 1'b1) begin
      failures++; $display("FAIL reset_prereq_irq got=%b exp=1", bus.irq);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (bus.irq !== 1'b0) begin
      failures++; $display("FAIL reset_irq_async got=%b exp=0", bus.irq);
    end
    bus.addr = A_EN; #1;
    checks++;
    if (bus.dout !== 8'h00) begin
      failures++; $display("FAIL reset_en got=%h exp=00", bus.dout);
    end
    bus.addr = A_PEND; #1;
    checks++;
    if (bus.dout !== 8'h00) begin
      failures++; $display("FAIL reset_pend got=%h exp=00", bus.dout);
    end
    bus.addr = A_EOI; #1;
    checks++;
    if (bus.dout !== 8'h00) begin
      failures++; $display("FAIL reset_state got=%h exp=00", bus.dout);
    end
    tick();
    rst = 1'b0;
    $display("reset: irq=%b", bus.irq);
  endtask

  task automatic test_basic();
    bus_write(A_EN, 8'h01);
    irq_src = 8'h01;
    tick();
    irq_src = 8'h00;
    bus.addr = A_PEND; #1;
    checks++;
    if (bus.dout !== 8'h01 || bus.irq !== 1'b0) begin
      failures++; $display("FAIL basic_pend got=%h irq=%b exp=01 irq=0", bus.dout, bus.irq);
    end
    tick();
    checks++;
    if (bus.irq !== 1'b1 || bus.irq_vec !== 3'd0) begin
      failures++; $display("FAIL basic_irq got=%b vec=%0d exp=1 vec=0", bus.irq, bus.irq_vec);
    end
    pulse_ack();
    bus.addr = A_PEND; #1;
    checks++;
    if (bus.irq !== 1'b0 || bus.dout !== 8'h00) begin
      failures++; $display("FAIL basic_ack got irq=%b pend=%h exp irq=0 pend=00", bus.irq, bus.dout);
    end
    bus.addr = A_EOI; #1;
    checks++;
    if (bus.dout !== 8'h08) begin
      failures++; $display("FAIL basic_busy got=%h exp=08", bus.dout);
    end
    bus_write(A_EOI, 8'h00);
    #1;
    checks++;
    if (bus.dout !== 8'h00) begin
      failures++; $display("FAIL basic_eoi got=%h exp=00", bus.dout);
    end
    $display("basic: handshake done, eoi read=%h", bus.dout);
  endtask

  task automatic test_priority();
    bus_write(A_EN, 8'hFF);
    irq_src = 8'h24;
    tick();
    irq_src = 8'h00;
    tick();
    checks++;
    if (bus.irq !== 1'b1 || bus.irq_vec !== 3'd2) begin
      failures++; $display("FAIL prio_first got irq=%b vec=%0d exp irq=1 vec=2", bus.irq, bus.irq_vec);
    end
    bus_write(A_EOI, 8'h00);
    checks++;
    if (bus.irq !== 1'b1 || bus.irq_vec !== 3'd2) begin
      failures++; $display("FAIL prio_eoi_ignored got irq=%b vec=%0d exp irq=1 vec=2", bus.irq, bus.irq_vec);
    end
    pulse_ack();
    checks++;
    if (bus.irq !== 1'b0) begin
      failures++; $display("FAIL prio_ack got irq=%b exp=0", bus.irq);
    end
    bus_write(A_EOI, 8'h00);
    tick();
    checks++;
    if (bus.irq !== 1'b1 || bus.irq_vec !== 3'd5) begin
      failures++; $display("FAIL prio_second got irq=%b vec=%0d exp irq=1 vec=5", bus.irq, bus.irq_vec);
    end
    pulse_ack();
    bus_write(A_EOI, 8'h00);
    bus.addr = A_PEND; #1;
    checks++;
    if (bus.dout !== 8'h00 || bus.irq !== 1'b0) begin
      failures++; $display("FAIL prio_clean got pend=%h irq=%b exp pend=00 irq=0", bus.dout, bus.irq);
    end
    $display("priority: served vec 2 then 5");
  endtask

  task automatic test_withdrawal();
    irq_src = 8'h08;
    tick();
    irq_src = 8'h00;
    tick();
    checks++;
    if (bus.irq !== 1'b1 || bus.irq_vec !== 3'd3) begin
      failures++; $display("FAIL wd_req got irq=%b vec=%0d exp irq=1 vec=3", bus.irq, bus.irq_vec);
    end
    bus_write(A_EN, 8'h00);
    tick();
    bus.addr = A_EOI; #1;
    checks++;
    if (bus.irq !== 1'b0 || bus.dout !== 8'h03) begin
      failures++; $display("FAIL wd_idle got irq=%b eoi=%h exp irq=0 eoi=03", bus.irq, bus.dout);
    end
    bus.addr = A_PEND; #1;
    checks++;
    if (bus.dout !== 8'h08) begin
      failures++; $display("FAIL wd_pend got=%h exp=08", bus.dout);
    end
    bus_write(A_PEND, 8'h08);
    #1;
    checks++;
    if (bus.dout !== 8'h00) begin
      failures++; $display("FAIL wd_w1c got=%h exp=00", bus.dout);
    end
    $display("withdrawal: request dropped, pend kept");
  endtask

  task automatic test_collision();
    irq_src = 8'h08;
    bus_write(A_PEND, 8'h08);
    irq_src = 8'h00;
    #1;
    checks++;
    if (bus.dout !== 8'h08) begin
      failures++; $display("FAIL collision got=%h exp=08", bus.dout);
    end
    bus_write(A_PEND, 8'hFF);
    #1;
    checks++;
    if (bus.dout !== 8'h00) begin
      failures++; $display("FAIL collision_clear got=%h exp=00", bus.dout);
    end
    $display("collision: set beat clear");
  endtask

  task automatic test_edge_level();
    logic [7:0] exp_pend;
`ifdef IRQ_EDGE_EN
    exp_pend = 8'h00;
`else
    exp_pend = 8'h02;
`endif
    bus_write(A_EN, 8'h02);
    irq_src = 8'h02;
    tick();
    tick();
    checks++;
    if (bus.irq !== 1'b1 || bus.irq_vec !== 3'd1) begin
      failures++; $display("FAIL el_req got irq=%b vec=%0d exp irq=1 vec=1", bus.irq, bus.irq_vec);
    end
    pulse_ack();
    bus_write(A_PEND, 8'h02);
    tick();
    #1;
    checks++;
    if (bus.dout !== exp_pend) begin
      failures++; $display("FAIL el_repend got=%h exp=%h", bus.dout, exp_pend);
    end
    irq_src = 8'h00;
    bus_write(A_PEND, 8'hFF);
    bus_write(A_EOI, 8'h00);
    tick();
    bus.addr = A_EOI; #1;
    checks++;
    if (bus.dout !== 8'h01 || bus.irq !== 1'b0) begin
      failures++; $display("FAIL el_final got eoi=%h irq=%b exp eoi=01 irq=0", bus.dout, bus.irq);
    end
    $display("edge_level: pend after w1c=%h", exp_pend);
  endtask

  initial begin
    bus.addr    = 16'h0000;
    bus.we      = 1'b0;
    bus.di      = 8'h00;
    bus.irq_ack = 1'b0;
    test_reset();
    test_basic();
    test_priority();
    test_withdrawal();
    test_collision();
    test_edge_level();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
